// File: rtl/shift_round_pipe.sv
// shift_round_pipe: two-stage right-shift, round-to-nearest-even and saturating narrow.
// Stage 1 captures the shifted magnitude with its guard and sticky bits; stage 2 rounds,
// saturates to OUT_WIDTH bits and registers the result with inexact/overflow flags.
module shift_round_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_inexact,
  output logic                   out_overflow
);

  localparam logic [SHIFT_WIDTH-1:0] ShiftOne = SHIFT_WIDTH'(1);
  localparam logic [SHIFT_WIDTH-1:0] ShiftTwo = SHIFT_WIDTH'(2);
  localparam logic [SHIFT_WIDTH-1:0] ShiftW   = SHIFT_WIDTH'(WIDTH);
  localparam logic [SHIFT_WIDTH-1:0] ShiftW1  = SHIFT_WIDTH'(WIDTH + 1);

  // Pipeline control
  logic adv1, adv2;
  logic v1_q, v2_q;

  // Stage 1 state and next-state
  logic [WIDTH-1:0] q1_q, q1_d;
  logic             g1_q, g1_d;
  logic             s1_q, s1_d;

  // Stage 2 state and next-state
  logic [OUT_WIDTH-1:0] data2_q, data2_d;
  logic                 inexact2_q, inexact2_d;
  logic                 ovf2_q, ovf2_d;

  // Shift-by-(s-1) helpers, held in WIDTH+1 bits so s = WIDTH+1 does not overflow
  logic [SHIFT_WIDTH-1:0] s_m1;
  logic [WIDTH:0]         one_ext, data_ext, sticky_mask, guard_vec;

  // Rounding intermediates
  logic           round_up;
  logic [WIDTH:0] rounded;

  // Handshake chain: a stage may advance when it is empty or its consumer advances
  always_comb begin
    adv2     = !v2_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
  end

  // Stage 1 datapath: shift, guard extraction and sticky reduction of discarded bits
  always_comb begin
    s_m1        = in_shift - ShiftOne;
    one_ext     = {{WIDTH{1'b0}}, 1'b1};
    data_ext    = {1'b0, in_data};
    sticky_mask = (one_ext << s_m1) - one_ext;
    guard_vec   = data_ext >> s_m1;

    q1_d = (in_shift >= ShiftW) ? '0 : (in_data >> in_shift);
    g1_d = (in_shift >= ShiftOne && in_shift <= ShiftW) ? guard_vec[0] : 1'b0;

    if (in_shift < ShiftTwo) begin
      s1_d = 1'b0;
    end else if (in_shift <= ShiftW1) begin
      s1_d = |(data_ext & sticky_mask);
    end else begin
      s1_d = |in_data;
    end
  end

  // Stage 2 datapath: round to nearest even, then saturate to OUT_WIDTH bits
  always_comb begin
    round_up   = g1_q & (s1_q | q1_q[0]);
    rounded    = {1'b0, q1_q} + {{WIDTH{1'b0}}, round_up};
    ovf2_d     = |rounded[WIDTH:OUT_WIDTH];
    data2_d    = ovf2_d ? '1 : rounded[OUT_WIDTH-1:0];
    inexact2_d = g1_q | s1_q;
  end

  // Stage 1 registers: valid follows in_valid whenever the stage advances
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1_q <= 1'b0;
      q1_q <= '0;
      g1_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
      end
      if (in_valid && adv1) begin
        q1_q <= q1_d;
        g1_q <= g1_d;
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2 registers: held stable while the consumer stalls
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v2_q       <= 1'b0;
      data2_q    <= '0;
      inexact2_q <= 1'b0;
      ovf2_q     <= 1'b0;
    end else if (adv2) begin
      v2_q       <= v1_q;
      data2_q    <= data2_d;
      inexact2_q <= inexact2_d;
      ovf2_q     <= ovf2_d;
    end
  end

  // Registered outputs
  always_comb begin
    out_valid    = v2_q;
    out_data     = data2_q;
    out_inexact  = inexact2_q;
    out_overflow = ovf2_q;
  end

endmodule

// File: tb/tb_shift_round_pipe.sv
// Directed bench for shift_round_pipe (WIDTH=16, OUT_WIDTH=8).
module tb_shift_round_pipe;

  logic       clock;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [15:0] in_data;
  logic [4:0] in_shift;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_inexact;
  logic       out_overflow;

  int checks;
  int failures;

  localparam int NV = 11;
  // Hand-computed vectors: in_data, in_shift -> out_data, out_inexact, out_overflow
  localparam logic [15:0] VD [NV] = '{16'h0180, 16'h0080, 16'h0081, 16'h0012, 16'hFFFF,
                                      16'h0100, 16'h8000, 16'h8001, 16'h8000, 16'h0000,
                                      16'h0001};
  localparam logic [4:0]  VS [NV] = '{5'd8, 5'd8, 5'd8, 5'd0, 5'd8, 5'd0, 5'd16, 5'd16,
                                      5'd17, 5'd31, 5'd20};
  localparam logic [7:0]  VO [NV] = '{8'h02, 8'h00, 8'h01, 8'h12, 8'hFF, 8'hFF, 8'h00,
                                      8'h01, 8'h00, 8'h00, 8'h00};
  localparam logic        VX [NV] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                      1'b1, 1'b0, 1'b1};
  localparam logic        VV [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0};

  shift_round_pipe #(
    .WIDTH      (16),
    .OUT_WIDTH  (8),
    .SHIFT_WIDTH(5)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shift    (in_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact),
    .out_overflow(out_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    resetn    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    out_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got %h want 00", out_data);
    end
    checks++;
    if (out_inexact !== 1'b0 || out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got inexact=%b overflow=%b want 0 0", out_inexact, out_overflow);
    end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed_vectors();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_data  = VD[i];
      in_shift = VS[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL vec%0d_valid got %b want 1", i, out_valid);
      end
      checks++;
      if (out_data !== VO[i] || out_inexact !== VX[i] || out_overflow !== VV[i]) begin
        failures++;
        $display("FAIL vec%0d_result got data=%h inexact=%b overflow=%b want %h %b %b",
                 i, out_data, out_inexact, out_overflow, VO[i], VX[i], VV[i]);
      end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL vec%0d_drain got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        in_valid = 1'b1;
        in_data  = VD[c];
        in_shift = VS[c];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clock); #1;
      if (c >= 1 && c <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== VO[c-1] || out_inexact !== VX[c-1] ||
            out_overflow !== VV[c-1]) begin
          failures++;
          $display("FAIL b2b_beat%0d got valid=%b data=%h inexact=%b overflow=%b want 1 %h %b %b",
                   c - 1, out_valid, out_data, out_inexact, out_overflow,
                   VO[c-1], VX[c-1], VV[c-1]);
        end
      end else if (c == 0 || c == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL b2b_idle_c%0d got out_valid=%b want 0", c, out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int   accepted;
    logic exp_rdy;
    accepted  = 0;
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = VD[5+j];
      in_shift = VS[5+j];
      #1;
      exp_rdy = (j < 2);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL bp_offer%0d_in_ready got %b want %b", j, in_ready, exp_rdy);
      end
      if (in_ready === 1'b1) accepted++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (accepted != 2) begin
      failures++; $display("FAIL bp_accepted got %0d want 2", accepted);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_full_in_ready got %b want 0", in_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== VO[5] || out_overflow !== VV[5] ||
        out_inexact !== VX[5]) begin
      failures++;
      $display("FAIL bp_held got valid=%b data=%h inexact=%b overflow=%b want 1 %h %b %b",
               out_valid, out_data, out_inexact, out_overflow, VO[5], VX[5], VV[5]);
    end
    // Release for one cycle while offering a new beat: accept and consume on the same edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = VD[2];
    in_shift  = VS[2];
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_data !== VO[5]) begin
      failures++; $display("FAIL bp_release_stable got %h want %h", out_data, VO[5]);
    end
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== VO[6] || out_inexact !== VX[6] ||
        out_overflow !== VV[6]) begin
      failures++;
      $display("FAIL bp_second got valid=%b data=%h inexact=%b overflow=%b want 1 %h %b %b",
               out_valid, out_data, out_inexact, out_overflow, VO[6], VX[6], VV[6]);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_refull_in_ready got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== VO[2] || out_inexact !== VX[2]) begin
      failures++;
      $display("FAIL bp_third got valid=%b data=%h inexact=%b want 1 %h %b",
               out_valid, out_data, out_inexact, VO[2], VX[2]);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_flight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = VD[4];
    in_shift  = VS[4];
    @(posedge clock); #1;
    in_data  = VD[0];
    in_shift = VS[0];
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
      failures++;
      $display("FAIL rst_pre got valid=%b data=%h want 1 ff", out_valid, out_data);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_inexact !== 1'b0 ||
        out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got valid=%b data=%h inexact=%b overflow=%b want 0 00 0 0",
               out_valid, out_data, out_inexact, out_overflow);
    end
    @(posedge clock); #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_release_valid got %b want 0", out_valid);
    end
    in_valid = 1'b1;
    in_data  = VD[0];
    in_shift = VS[0];
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_latency_early got out_valid=%b want 0", out_valid);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== VO[0] || out_inexact !== VX[0] ||
        out_overflow !== VV[0]) begin
      failures++;
      $display("FAIL rst_after got valid=%b data=%h inexact=%b overflow=%b want 1 %h %b %b",
               out_valid, out_data, out_inexact, out_overflow, VO[0], VX[0], VV[0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
